// File: rtl/seq1001_tx.sv
// Serializer: each accepted load sends preamble 1,0,0,1 then DATA_W payload bits MSB first (+ optional parity).
// Latency: the first frame bit is on x right after the accept edge; done pulses on the edge after the last bit.
// Backpressure: ready is low for the whole frame, so load is ignored until the done/idle cycle.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high; wins over a simultaneous load and aborts a frame in flight
//   data_in  - DATA_W-bit payload, captured only when load && ready
//   load     - start-of-frame request
//   ready    - registered; high when a load will be taken at the next edge
//   x        - registered serial line, idle 0
//   busy     - registered; high while a frame bit is on x
//   done     - registered one-cycle completion pulse (x=0 in that cycle)
//
// Optional feature: define SEQ1001_TX_PARITY_EN to append one even-parity bit
// (XOR of the payload) after the last data bit.
module seq1001_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              done
);

    // Bit counter indexes the bit currently on x (0..4+DATA_W); one spare count
    // keeps the parity position representable without wrapping.
    localparam int CNT_W = $clog2(DATA_W + 6);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(4 + DATA_W - 1);

`ifdef SEQ1001_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        PARITY   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;
`endif

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] sr, sr_nxt;
    logic              x_nxt, busy_nxt, ready_nxt, done_nxt;
`ifdef SEQ1001_TX_PARITY_EN
    logic              par, par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            x     <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
`ifdef SEQ1001_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
            x     <= x_nxt;
            busy  <= busy_nxt;
            ready <= ready_nxt;
            done  <= done_nxt;
`ifdef SEQ1001_TX_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    // Next-state logic computes the value each output register takes at the
    // coming edge, so x/busy/ready/done are pure flops with no path from load.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        x_nxt     = 1'b0;
        busy_nxt  = 1'b1;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
`ifdef SEQ1001_TX_PARITY_EN
        par_nxt   = par;
`endif
        unique case (state)
            IDLE: begin
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
                if (load && ready) begin
                    state_nxt = PREAMBLE;
                    cnt_nxt   = '0;
                    sr_nxt    = data_in;
                    x_nxt     = 1'b1;       // first preamble bit
                    busy_nxt  = 1'b1;
                    ready_nxt = 1'b0;
`ifdef SEQ1001_TX_PARITY_EN
                    par_nxt   = ^data_in;
`endif
                end
            end
            PREAMBLE: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == PRE_LAST) begin
                    state_nxt = DATA;
                    x_nxt     = sr[DATA_W-1];
                    sr_nxt    = sr << 1;
                end else begin
                    // Preamble 1,0,0,1: the bit following position 2 is the closing 1.
                    x_nxt = (cnt[1:0] == 2'd2);
                end
            end
            DATA: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == DATA_LAST) begin
`ifdef SEQ1001_TX_PARITY_EN
                    state_nxt = PARITY;
                    x_nxt     = par;
`else
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    done_nxt  = 1'b1;
`endif
                end else begin
                    x_nxt  = sr[DATA_W-1];
                    sr_nxt = sr << 1;
                end
            end
`ifdef SEQ1001_TX_PARITY_EN
            PARITY: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
                done_nxt  = 1'b1;
            end
`endif
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/seq1001_tx.md
SEQ1001_TX -- requirements
Module: seq1001_tx

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, payload bits per frame (legal range 1..16).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port data_in  input  DATA_W  parallel payload, sampled only on an accepted load.
REQ-005 SHALL provide port load  input  1  request to start a frame with data_in.
REQ-006 SHALL provide port ready  output  1  high when a load will be accepted at the next rising edge.
REQ-007 SHALL provide port x  output  1  registered serial line, one bit per clk cycle, idle level 0.
REQ-008 SHALL provide port busy  output  1  high while a frame is being shifted out.
REQ-009 SHALL provide port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL implement states IDLE, PREAMBLE, DATA, PARITY (PARITY only when compiled in).
REQ-011 SHALL accept a load on a rising edge where load=1 and ready=1, capturing data_in into an internal shift register.
REQ-012 SHALL, from the accept edge, drive x with preamble bits 1,0,0,1 on four consecutive cycles, then data bits MSB first on DATA_W cycles.
REQ-013 SHALL give a frame length of 4+DATA_W bit cycles (12 at default), plus 1 with parity.
REQ-014 SHALL, on the edge after the last frame bit, set x=0, busy=0, ready=1 and done=1 for exactly one cycle.
REQ-015 SHALL hold ready=0 and busy=1 for every cycle a frame bit is on x; load in those cycles SHALL be ignored, with no effect on the frame in progress.
REQ-016 SHALL accept a load during the done cycle, giving back-to-back frames separated by exactly one x=0 cycle.
REQ-017 SHALL keep x=0, busy=0, ready=1, done=0 in IDLE with no accepted load.
REQ-018 SHALL transmit payload bits unmodified, including payloads that contain 1001; framing disambiguation belongs to the receiver.
REQ-019 SHALL size the internal bit counter to count 4+DATA_W+1 without wrap; the counter SHALL reload to 0 at each accept.
REQ-020 SHALL register all outputs, with no combinational path from load or data_in to x.

Reset
REQ-021 SHALL, on any rising edge with reset=1, force IDLE, x=0, ready=1, busy=0, done=0, shift register and counter to 0.
REQ-022 SHALL give reset priority over a simultaneous load; that load SHALL be discarded.
REQ-023 SHALL abort a frame when reset is asserted mid-frame: no further frame bits and no done pulse.

Configuration
REQ-024 SHALL compile in a parity bit when macro SEQ1001_TX_PARITY_EN is defined: one extra cycle after the last data bit, x = even parity over the DATA_W payload bits (XOR of payload), with done following it.
REQ-025 SHALL, without SEQ1001_TX_PARITY_EN, omit the PARITY state, giving frames of exactly 4+DATA_W bits.

Verification
REQ-026 SHALL verify: reset, then load 0xA5 -> x = 1,0,0,1,1,0,1,0,0,1,0,1 on 12 consecutive cycles, then x=0 with done=1 for one cycle and ready=1.
REQ-027 SHALL verify: load 0x3C accepted, then load=1 with data_in=0xFF during bits 2..10 -> serialized payload stays 00111100, and no second frame starts before done.
REQ-028 SHALL verify: load held high with 0x00 then 0x81 -> frame 1001_00000000, one x=0 done cycle, then 1001_10000001.
REQ-029 SHALL verify: reset asserted during the 6th frame bit -> next edge x=0, busy=0, ready=1, and done never pulses for that frame.
REQ-030 SHALL verify: with SEQ1001_TX_PARITY_EN, load 0x07 -> 13 bits 1001_00000111_1, then done; without the macro -> 12 bits, then done.
REQ-031 SHALL verify: reset and load both high on the same edge with 0x55 -> remains IDLE, x=0 for the following 12 cycles.
